// File: rtl/msdap_conv_sched.sv
// MSDAP convolution scheduler: walks 16 Rj groups of signed-delay coefficients and accumulates one output sample.
// Define MSDAP_SCHED_OVF_EN to add the sticky accumulator-overflow output ovf.
module msdap_conv_sched (
   input  logic        sClk,
   input  logic        reset,
   input  logic        start_calc,
   input  logic        clear,
   input  logic [7:0]  newest_ptr,
   input  logic [8:0]  samples_seen,
   output logic [3:0]  rj_addr,
   input  logic [15:0] rj_data,
   output logic [8:0]  coef_addr,
   input  logic [15:0] coef_data,
   output logic [7:0]  data_addr,
   input  logic [15:0] data_in,
   output logic        busy,
   output logic        out_valid,
   output logic [39:0] y_out
`ifdef MSDAP_SCHED_OVF_EN
   ,
   output logic        ovf
`endif
);

   localparam int unsigned ACC_W  = 40;
   localparam int unsigned SMP_W  = 16;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned J_W    = 4;
   localparam int unsigned CA_W   = 9;
   localparam int unsigned DA_W   = 8;
   localparam int unsigned K_W    = 8;
   localparam int unsigned EXT_W  = ACC_W - SMP_W - 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RJ_RD  = 3'd1,
      RJ_LAT = 3'd2,
      C_RD   = 3'd3,
      D_RD   = 3'd4,
      ACC    = 3'd5,
      SHIFT  = 3'd6,
      DONE   = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [J_W-1:0]     j_q, j_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CA_W-1:0]    coef_addr_q, coef_addr_d;
   logic [DA_W-1:0]    data_addr_q, data_addr_d;
   logic               sign_q, sign_d;
   logic [K_W-1:0]     k_q, k_d;
   logic               busy_q, busy_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   y_out_q, y_out_d;

   logic [DA_W-1:0]    data_addr_c;
   logic [ACC_W-1:0]   term_c;
   logic [ACC_W-1:0]   sum_c;
   logic [ACC_W-1:0]   dif_c;
   logic               term_use_c;
   logic               unused_coef_bits;

`ifdef MSDAP_SCHED_OVF_EN
   logic               ovf_q, ovf_d;
   logic               ovf_add_c;
   logic               ovf_sub_c;
`endif

   // Delay-line address of x[n-k] and the sample scaled into acc bits 39:16.
   assign data_addr_c = newest_ptr - coef_data[K_W-1:0];
   assign term_c      = {{EXT_W{data_in[SMP_W-1]}}, data_in, 16'h0000};
   assign sum_c       = acc_q + term_c;
   assign dif_c       = acc_q - term_c;
   assign term_use_c  = ({1'b0, k_q} < samples_seen);

   assign unused_coef_bits = ^coef_data[15:9];

`ifdef MSDAP_SCHED_OVF_EN
   assign ovf_add_c = (acc_q[ACC_W-1] == term_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc_q[ACC_W-1]);
   assign ovf_sub_c = (acc_q[ACC_W-1] != term_c[ACC_W-1]) && (dif_c[ACC_W-1] != acc_q[ACC_W-1]);
   assign ovf       = ovf_q;
`endif

   // Data address must be on the bus during D_RD so the sample arrives in ACC.
   assign data_addr = (state_q == D_RD) ? data_addr_c : data_addr_q;
   assign rj_addr   = j_q;
   assign coef_addr = coef_addr_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign y_out     = y_out_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      j_d         = j_q;
      cnt_d       = cnt_q;
      coef_addr_d = coef_addr_q;
      data_addr_d = data_addr_q;
      sign_d      = sign_q;
      k_d         = k_q;
      out_valid_d = 1'b0;
      y_out_d     = y_out_q;
`ifdef MSDAP_SCHED_OVF_EN
      ovf_d       = ovf_q;
`endif

      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_calc) begin
                  state_d     = RJ_RD;
                  acc_d       = '0;
                  j_d         = '0;
                  coef_addr_d = '0;
`ifdef MSDAP_SCHED_OVF_EN
                  ovf_d       = 1'b0;
`endif
               end
            end
            RJ_RD: begin
               state_d = RJ_LAT;
            end
            RJ_LAT: begin
               cnt_d   = rj_data;
               state_d = (rj_data != CNT_W'(0)) ? C_RD : SHIFT;
            end
            C_RD: begin
               state_d = D_RD;
            end
            D_RD: begin
               data_addr_d = data_addr_c;
               sign_d      = coef_data[8];
               k_d         = coef_data[K_W-1:0];
               state_d     = ACC;
            end
            ACC: begin
               if (term_use_c) begin
                  acc_d = sign_q ? dif_c : sum_c;
`ifdef MSDAP_SCHED_OVF_EN
                  if (sign_q ? ovf_sub_c : ovf_add_c) begin
                     ovf_d = 1'b1;
                  end
`endif
               end
               coef_addr_d = coef_addr_q + CA_W'(1);
               cnt_d       = cnt_q - CNT_W'(1);
               state_d     = (cnt_q != CNT_W'(1)) ? C_RD : SHIFT;
            end
            SHIFT: begin
               acc_d   = {acc_q[ACC_W-1], acc_q[ACC_W-1:1]};
               j_d     = j_q + J_W'(1);
               state_d = (j_q == J_W'(15)) ? DONE : RJ_RD;
            end
            DONE: begin
               y_out_d     = acc_q;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sClk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         j_q         <= '0;
         cnt_q       <= '0;
         coef_addr_q <= '0;
         data_addr_q <= '0;
         sign_q      <= 1'b0;
         k_q         <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         y_out_q     <= '0;
`ifdef MSDAP_SCHED_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         j_q         <= j_d;
         cnt_q       <= cnt_d;
         coef_addr_q <= coef_addr_d;
         data_addr_q <= data_addr_d;
         sign_q      <= sign_d;
         k_q         <= k_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         y_out_q     <= y_out_d;
`ifdef MSDAP_SCHED_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

endmodule

// File: doc/msdap_conv_sched.md
MSDAP_CONV_SCHED -- requirements
Module: msdap_conv_sched

Interface
REQ-001 SHALL have the following ports, each given as name, direction, width and meaning:
  sClk  in  1  system clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  start_calc  in  1  one-cycle pulse requesting convolution of the newest sample.
  clear  in  1  synchronous abort, used for sleep/soft reset.
  newest_ptr  in  8  data-RAM address of the newest sample x[n].
  samples_seen  in  9  number of valid samples stored; saturates at 256.
  rj_addr  out  4  Rj RAM read address.
  rj_data  in  16  Rj value; valid 1 cycle after rj_addr.
  coef_addr  out  9  coefficient RAM read address.
  coef_data  in  16  coefficient; bit 8 = sign, bits 7:0 = delay k; valid 1 cycle after coef_addr.
  data_addr  out  8  data RAM read address.
  data_in  in  16  signed sample; valid 1 cycle after data_addr.
  busy  out  1  high in any state except IDLE.
  out_valid  out  1  one-cycle pulse; y_out is valid.
  y_out  out  40  signed result, held until the next DONE.

Function
REQ-002 SHALL implement the following states: IDLE, RJ_RD, RJ_LAT, C_RD, D_RD, ACC, SHIFT, DONE.
REQ-003 SHALL move from IDLE to RJ_RD when start_calc=1 is sampled, and SHALL clear acc, group index j and coef_addr to 0 on that transition.
REQ-004 SHALL hold start_calc=1 sampled outside IDLE with no effect.
REQ-005 SHALL drive rj_addr=j in RJ_RD, and SHALL latch rj_data into a remaining-count register in RJ_LAT.
REQ-006 SHALL go from RJ_LAT to C_RD if the count is nonzero, and to SHIFT if the count is 0.
REQ-007 SHALL present coef_addr in C_RD.
REQ-008 SHALL, in D_RD, drive data_addr = (newest_ptr - coef_data[7:0]) mod 256 (8-bit wrap) and latch sign and k.
REQ-009 SHALL, in ACC, add or subtract the weighted sample to/from acc: subtract if sign=1, add otherwise.
REQ-010 SHALL drop the ACC term (acc unchanged) if k >= samples_seen.
REQ-011 SHALL, in ACC, increment coef_addr (9-bit wrap) and decrement the count, then go to C_RD if the count is nonzero, else to SHIFT.
REQ-012 SHALL form the weighted sample as data_in sign-extended into bits 39:16, with bits 15:0 = 0.
REQ-013 SHALL, in SHIFT, arithmetic-shift acc right by 1 and increment j, then go to DONE if j was 15, else to RJ_RD.
REQ-014 SHALL, in DONE, load y_out=acc, pulse out_valid=1 and return to IDLE.
REQ-015 SHALL assert out_valid exactly 49+3*S cycles after start_calc is sampled, where S = sum of Rj[0..15].
REQ-016 SHALL wrap all arithmetic modulo 2^40 with no saturation.
REQ-017 SHALL, on clear=1 in any state, go to IDLE on the next edge with busy=0 and no out_valid, and SHALL leave y_out unchanged.
REQ-018 SHALL give clear priority over start_calc when both are high in the same cycle.

Reset
REQ-019 SHALL, on reset=1, immediately force: state=IDLE; busy=0; out_valid=0; y_out=0; rj_addr=0; coef_addr=0; data_addr=0; acc=0; j=0.
REQ-020 SHALL abort any computation in progress when reset is asserted, and SHALL produce no out_valid for it.

Configuration
REQ-021 SHALL, with macro MSDAP_SCHED_OVF_EN defined, add output ovf (1 bit, reset 0).
REQ-022 SHALL set ovf sticky on any signed overflow of an ACC add/sub, and SHALL clear it on the IDLE-to-RJ_RD transition.
REQ-023 SHALL, without MSDAP_SCHED_OVF_EN, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-024 SHALL cover reset mid-computation (j=7): assert reset -> busy=0, y_out=0x0000000000 immediately, no out_valid afterwards.
REQ-025 SHALL cover Rj[15]=1 (others 0), coef[0]=0x0000, x[n]=0x0001, samples_seen=1 -> out_valid at cycle 52, y_out=0x0000008000.
REQ-026 SHALL cover Rj[0]=1 (others 0), coef[0]=0x0100, x[n]=0x0004 -> out_valid at cycle 52, y_out=0xFFFFFFFFFC.
REQ-027 SHALL cover newest_ptr=0x02, coef k=5, samples_seen=256 -> data_addr=0xFD; the same with samples_seen=3 -> term skipped, y_out=0.
REQ-028 SHALL cover clear at cycle 20 of a computation with S=10 -> IDLE next edge, no out_valid, y_out keeps its prior value; start_calc while busy -> ignored.
REQ-029 SHALL cover, with MSDAP_SCHED_OVF_EN, 512 coefficients of sign=0 on x=0x7FFF -> result wraps, ovf=1; the next start_calc clears ovf.
